// File: rtl/rib_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rib_pkg
// Description : Shared definitions for the rib interconnect: slave base
//               nibbles, timer register offsets, CTRL bit indices and the
//               timer state type.
// Revision    : 1.0  initial release
// ============================================================================
package rib_pkg;

    // Slave base nibbles (addr[31:28]) as decoded by the interconnect
    localparam logic [3:0] SLAVE_MEM   = 4'b0000;
    localparam logic [3:0] SLAVE_UART  = 4'b0001;
    localparam logic [3:0] SLAVE_TIMER = 4'b0010;
    localparam logic [3:0] SLAVE_GPIO  = 4'b0011;

    // Timer word offsets (addr[3:2])
    localparam logic [1:0] TIMER_CTRL     = 2'd0;
    localparam logic [1:0] TIMER_COUNT    = 2'd1;
    localparam logic [1:0] TIMER_VALUE    = 2'd2;
    localparam logic [1:0] TIMER_PRESCALE = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IE     = 1;
    localparam int CTRL_PEND   = 2;
    localparam int CTRL_RELOAD = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        MATCH = 2'd2
    } timer_state_e;

endpackage : rib_pkg
`default_nettype wire

// File: rtl/rib_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : rib_timer_prescaler
// Description : Prescaler counter for rib_timer. Counts while enabled and
//               emits a one-cycle tick when the count equals the divider,
//               then restarts from zero. clr has priority over counting.
// Revision    : 1.0  initial release
// ============================================================================
module rib_timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PRESCALE_W-1:0] div_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;

    // The tick belongs to the current cycle, so the caller sees it even when
    // the counter is being cleared this same cycle.
    assign tick_o = en_i && (pcnt_q == div_i);

    // Next prescaler count: clear, wrap on tick, or increment while enabled
    always_comb begin
        pcnt_d = pcnt_q;
        if (clr_i) begin
            pcnt_d = '0;
        end else if (en_i) begin
            pcnt_d = tick_o ? '0 : pcnt_q + PRESCALE_W'(1);
        end
    end

    // Prescaler count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule : rib_timer_prescaler
`default_nettype wire

// File: rtl/rib_timer.sv
`default_nettype none
// ============================================================================
// Module      : rib_timer
// Description : rib slave-2 timer. 32-bit COUNT with compare/match, one-shot
//               or auto-reload, level interrupt. Zero-wait-state register
//               access with combinational read data.
//               Build option RIB_TIMER_PRESCALER_EN adds the PRESCALE
//               register and prescaler counter; without it every running
//               cycle is a tick.
// Revision    : 1.0  initial release
// ============================================================================
module rib_timer
    import rib_pkg::*;
#(
    parameter int          PRESCALE_W = 16,
    parameter logic [31:0] RST_VALUE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        we_i,
    output logic        int_o
);

    if (PRESCALE_W < 1 || PRESCALE_W > 32) begin : g_bad_prescale_w
        $error("rib_timer: PRESCALE_W must be within 1..32");
    end

    timer_state_e state_q, state_d;
    logic         en_q, en_d;
    logic         ie_q, ie_d;
    logic         pend_q, pend_d;
    logic         reload_q, reload_d;
    logic [31:0]  count_q, count_d;
    logic [31:0]  value_q, value_d;

    logic w_addr_ok;
    logic w_wr_ctrl;
    logic w_wr_count;
    logic w_wr_value;
    logic w_running;
    logic w_tick;
    logic w_match;

    // Upper nibble is consumed by the interconnect; byte offset is unused
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:28], addr_i[1:0]};

    assign w_addr_ok  = (addr_i[27:4] == 24'd0);
    assign w_wr_ctrl  = we_i && w_addr_ok && (addr_i[3:2] == TIMER_CTRL);
    assign w_wr_count = we_i && w_addr_ok && (addr_i[3:2] == TIMER_COUNT);
    assign w_wr_value = we_i && w_addr_ok && (addr_i[3:2] == TIMER_VALUE);
    assign w_running  = (state_q != IDLE);

`ifdef RIB_TIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  w_wr_prescale;
    logic                  w_pcnt_clr;

    assign w_wr_prescale = we_i && w_addr_ok && (addr_i[3:2] == TIMER_PRESCALE);
    // Software stopping the timer restarts the prescale period
    assign w_pcnt_clr    = w_running && w_wr_ctrl && !data_i[CTRL_EN];

    rib_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en_i   (w_running),
        .clr_i  (w_pcnt_clr),
        .div_i  (prescale_q),
        .tick_o (w_tick)
    );

    // PRESCALE register next value
    always_comb begin
        prescale_d = prescale_q;
        if (w_wr_prescale) begin
            prescale_d = data_i[PRESCALE_W-1:0];
        end
    end

    // PRESCALE register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end
`else
    assign w_tick = w_running;
`endif

    // A zero compare value disables matching so COUNT can free-run and wrap
    assign w_match = (state_q == RUN) && w_tick && (value_q != 32'd0) &&
                     (count_q == value_q);

    assign int_o = pend_q && ie_q;

    // Register updates and state transition. Ordering encodes priority:
    // hardware pend set beats W1C, hardware en clear beats a write, and a
    // software COUNT write beats both tick increment and match clear.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        ie_d     = ie_q;
        pend_d   = pend_q;
        reload_d = reload_q;
        count_d  = count_q;
        value_d  = value_q;

        if (w_wr_ctrl) begin
            en_d     = data_i[CTRL_EN];
            ie_d     = data_i[CTRL_IE];
            reload_d = data_i[CTRL_RELOAD];
            if (data_i[CTRL_PEND]) begin
                pend_d = 1'b0;
            end
        end
        if (w_wr_value) begin
            value_d = data_i;
        end
        if ((state_q == RUN) && w_tick && !w_match) begin
            count_d = count_q + 32'd1;
        end
        if (state_q == MATCH) begin
            count_d = 32'd0;
            pend_d  = 1'b1;
            if (!reload_q) begin
                en_d = 1'b0;
            end
        end
        if (w_wr_count) begin
            count_d = data_i;
        end

        if (!en_d) begin
            state_d = IDLE;
        end else if (w_match) begin
            state_d = MATCH;
        end else begin
            state_d = RUN;
        end
    end

    // Timer state and register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            pend_q   <= 1'b0;
            reload_q <= 1'b0;
            count_q  <= 32'd0;
            value_q  <= RST_VALUE;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            ie_q     <= ie_d;
            pend_q   <= pend_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            value_q  <= value_d;
        end
    end

    // Side-effect-free combinational read mux
    always_comb begin
        data_o = 32'd0;
        if (w_addr_ok) begin
            case (addr_i[3:2])
                TIMER_CTRL:  data_o = {28'd0, reload_q, pend_q, ie_q, en_q};
                TIMER_COUNT: data_o = count_q;
                TIMER_VALUE: data_o = value_q;
`ifdef RIB_TIMER_PRESCALER_EN
                default:     data_o = 32'(prescale_q);
`else
                default:     data_o = 32'd0;
`endif
            endcase
        end
    end

endmodule : rib_timer
`default_nettype wire

// File: doc/rib_timer.md
Name: rib_timer

Overview:
- Bus responder for the rib interconnect's slave 2 port (address nibble 4'b0010). Provides a programmable 32-bit timer with prescaler, compare/match, one-shot or auto-reload mode, and a level interrupt to the core.
- Receives word addresses already stripped of the upper nibble by the interconnect.
- Single-cycle, zero-wait-state access: writes commit on the clock edge, read data is combinational.

Parameters:
- PRESCALE_W, 16, width of the prescaler divider register and counter.
- RST_VALUE, 32'h0000_0000, reset value of the VALUE (compare) register.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- addr_i  input  32  byte address from interconnect; bits [31:28] are always 0; only [3:2] decoded.
- data_i  input  32  write data.
- data_o  output  32  read data, combinational from addr_i and the register state.
- we_i  input  1  write strobe. Full-word write only; no byte enables.
- int_o  output  1  timer interrupt, level: int_o = CTRL.pend & CTRL.ie.

Behaviour:
- Register map, selected by addr_i[3:2]. addr_i[27:4] must be 0, otherwise reads return 0 and writes are ignored.
  - 0x0 CTRL: bit0 en, bit1 ie, bit2 pend (write-1-to-clear), bit3 reload (1 = auto-reload, 0 = one-shot). Other bits read 0.
  - 0x4 COUNT: read/write.
  - 0x8 VALUE: compare value, read/write.
  - 0xC PRESCALE: low PRESCALE_W bits read/write; upper bits read 0.
- Reads have no side effects. The interconnect drives addr 0 when slave 2 is not granted, so this is required.
- Reset values:
  - CTRL = 0, COUNT = 0, VALUE = RST_VALUE, PRESCALE = 0.
  - Internal prescaler counter pcnt = 0.
  - int_o = 0; data_o reflects CTRL, which is 0.
- State machine with states IDLE, RUN, MATCH:
  - IDLE (en=0): COUNT and pcnt hold. Writing en=1 moves to RUN on the next edge.
  - RUN: pcnt increments each cycle. When pcnt == PRESCALE, a tick is generated and pcnt returns to 0. With PRESCALE = 0, a tick occurs every cycle.
  - On each tick, COUNT increments.
  - If VALUE != 0 and COUNT == VALUE at a tick, go to MATCH instead of incrementing.
  - MATCH (one cycle): COUNT <= 0, pend <= 1. If reload=1 return to RUN; otherwise clear en and go to IDLE.
- Boundary conditions:
  - VALUE == 0: no match ever occurs. COUNT free-runs and wraps 0xFFFF_FFFF -> 0 with no interrupt.
  - Writing a VALUE below the current COUNT: no match until COUNT wraps around.
  - Software write to COUNT in the same cycle as a tick: the write wins and the tick's increment is dropped.
  - W1C of pend in the same cycle as a hardware set (MATCH): the set wins and pend stays 1.
  - Writing en=0 during RUN or MATCH: go to IDLE and clear pcnt to 0. A pend set in MATCH that same cycle still takes effect.
  - Reset asserted mid-count: all state returns to reset values immediately (asynchronous).
- Latency:
  - Register write visible on data_o the cycle after we_i.
  - int_o rises 1 cycle after the matching tick edge (the MATCH cycle edge).

Optional Feature:
- Macro: RIB_TIMER_PRESCALER_EN.
- Defined: PRESCALE register and pcnt are implemented as described above.
- Undefined: no pcnt logic; every RUN cycle is a tick. 0xC reads 0 and writes are ignored; PRESCALE_W is unused.

Decomposition:
- Shared package rib_pkg holds:
  - slave base nibbles (SLAVE_TIMER = 4'b0010, etc.);
  - timer register offsets (TIMER_CTRL = 2'd0, TIMER_COUNT = 2'd1, TIMER_VALUE = 2'd2, TIMER_PRESCALE = 2'd3);
  - CTRL bit indices;
  - the state enum typedef timer_state_e {IDLE, RUN, MATCH}.
- One sub-module, rib_timer_prescaler: pcnt counter with en, clr, and div inputs and a tick output. It is instantiated only under RIB_TIMER_PRESCALER_EN; otherwise tick = running.

Test Plan:
- Reset check: assert rst mid-run with COUNT = 5 -> all registers read back reset values, int_o = 0 immediately, and stays 0 after release.
- One-shot match: PRESCALE = 0, VALUE = 3, write CTRL = 0x3 -> COUNT reads 1, 2, 3, then 0. pend = 1 and int_o = 1 one cycle after the match tick; en self-clears and COUNT stays 0.
- Auto-reload with prescaler: PRESCALE = 2, VALUE = 2, CTRL = 0xB -> a tick every 3 cycles, a match every 9 cycles, and a repeated pend set. W1C of CTRL bit2 drops int_o the next cycle.
- Simultaneous events:
  - W1C pend in the exact MATCH cycle -> pend remains 1.
  - Write COUNT = 0x100 on a tick cycle -> COUNT reads 0x100, not 0x101.
- Wrap with VALUE = 0: COUNT = 0xFFFF_FFFE, en = 1, PRESCALE = 0 -> reads 0xFFFF_FFFF, then 0x0; pend never sets.
- Decode and macro: a write to addr 0x10 changes nothing and a read of it returns 0. With RIB_TIMER_PRESCALER_EN undefined, writing PRESCALE = 5 reads 0 and a tick occurs every cycle.
